dmem_bus_arbiter: RTL and testbench

- Arbitrates the single-ported data memory bus between the CPU load/store datapath (master 0), the stack unit (master 1) and the DMA/peripheral master (master 2).
- Produces the per-master bus grant that the stack unit and the other masters wait on, and multiplexes the owner's address, strobes and write data onto the memory bus.
- Round-robin fair, holds the grant across multi-byte sequences (for example a 3-byte push/pop), and uses a watchdog to revoke a stuck owner.

---
 rtl/dmem_bus_arbiter_pkg.sv | 20 ++
 rtl/dmem_bus_arbiter_if.sv | 39 +++
 rtl/dmem_bus_arbiter_rr_select.sv | 35 +++
 rtl/dmem_bus_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter: master indices,
// FSM state encoding and default bus geometry.
package dmem_bus_arbiter_pkg;

  localparam int unsigned MASTER_CPU   = 0;
  localparam int unsigned MASTER_STACK = 1;
  localparam int unsigned MASTER_DMA   = 2;

  localparam int unsigned DEF_NUM_MASTERS = 3;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_MAX_HOLD    = 16;

  typedef enum logic [1:0] {
    ARB_S     = 2'd0,
    OWN_S     = 2'd1,
    RELEASE_S = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Data-memory bus bundle: per-master request side plus the shared memory side.
interface dmem_bus_arbiter_if
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W
);
  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0]        m_wr;
  logic [NUM_MASTERS-1:0]        m_rd;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_grant;
  logic [DATA_W-1:0]             m_rdata;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_wr;
  logic                          mem_rd;
  logic [DATA_W-1:0]             mem_wdata;
  logic [DATA_W-1:0]             mem_rdata;
  logic                          timeout;
  logic [2:0]                    timeout_id;
  logic                          proto_err;

  // Arbiter side of the bundle.
  modport slave (
    input  m_req, m_addr, m_wr, m_rd, m_wdata, mem_rdata,
    output m_grant, m_rdata, mem_addr, mem_wr, mem_rd, mem_wdata,
    output timeout, timeout_id, proto_err
  );

  // Requesting masters and memory, seen from outside the arbiter.
  modport master (
    output m_req, m_addr, m_wr, m_rd, m_wdata, mem_rdata,
    input  m_grant, m_rdata, mem_addr, mem_wr, mem_rd, mem_wdata,
    input  timeout, timeout_id, proto_err
  );

endinterface

// File: rtl/dmem_bus_arbiter_rr_select.sv
// Round-robin next-requester search starting just above the last owner.
module dmem_bus_arbiter_rr_select
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [2:0]             last_i,
  output logic [NUM_MASTERS-1:0] onehot_o,
  output logic [2:0]             idx_o,
  output logic                   valid_o
);

  int unsigned            cand;
  logic [NUM_MASTERS-1:0] sh;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    sh       = '0;
    // Offsets 1..N visit every master once, the last owner being tried last.
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      cand = (32'(last_i) + off) % NUM_MASTERS;
      sh   = req_i >> cand;
      if (!valid_o && sh[0]) begin
        valid_o  = 1'b1;
        idx_o    = 3'(cand);
        onehot_o = NUM_MASTERS'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Data-memory bus arbiter: round-robin grant held per sequence, one-cycle
// release turnaround, watchdog revoke of a stuck owner.
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MAX_HOLD    = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  dmem_bus_arbiter_if.slave  bus
);

  localparam int unsigned         HOLD_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [2:0]             owner_q;
  logic [2:0]             last_q;
  logic [HOLD_W-1:0]      hold_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   timeout_q;
  logic [2:0]             timeout_id_q;

  logic [NUM_MASTERS-1:0] sel_onehot;
  logic [2:0]             sel_idx;
  logic                   sel_valid;

  logic [ADDR_W-1:0]      own_addr;
  logic [DATA_W-1:0]      own_wdata;
  logic                   own_req;
  logic                   own_wr;
  logic                   own_rd;

  dmem_bus_arbiter_rr_select #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_select (
    .req_i    (bus.m_req),
    .last_i   (last_q),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx),
    .valid_o  (sel_valid)
  );

  // grant_q is zero outside OWN, so AND-OR muxing also gates everything off.
  assign own_req = |(bus.m_req & grant_q);
  assign own_wr  = |(bus.m_wr & grant_q);
  assign own_rd  = |(bus.m_rd & grant_q);

  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        own_addr  |= bus.m_addr[i*ADDR_W +: ADDR_W];
        own_wdata |= bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.m_grant    = grant_q;
  assign bus.m_rdata    = bus.mem_rdata;
  assign bus.mem_addr   = (|grant_q) ? own_addr : addr_q;
  assign bus.mem_wdata  = (|grant_q) ? own_wdata : wdata_q;
  assign bus.mem_wr     = own_wr;
  assign bus.mem_rd     = own_rd & ~own_wr;
  assign bus.proto_err  = own_wr & own_rd;
  assign bus.timeout    = timeout_q;
  assign bus.timeout_id = timeout_id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_S;
      grant_q      <= '0;
      owner_q      <= '0;
      last_q       <= 3'(NUM_MASTERS - 1);
      hold_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ARB_S: begin
          if (sel_valid) begin
            grant_q <= sel_onehot;
            owner_q <= sel_idx;
            hold_q  <= '0;
            state_q <= OWN_S;
          end
        end
        OWN_S: begin
          addr_q  <= own_addr;
          wdata_q <= own_wdata;
          hold_q  <= hold_q + 1'b1;
          if (!own_req) begin
            grant_q <= '0;
            state_q <= RELEASE_S;
          end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
            grant_q      <= '0;
            state_q      <= RELEASE_S;
            timeout_q    <= 1'b1;
            timeout_id_q <= owner_q;
          end
        end
        RELEASE_S: begin
          last_q  <= owner_q;
          state_q <= ARB_S;
        end
        default: state_q <= ARB_S;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: a default instance and a MAX_HOLD=4
// instance share one stimulus stream.
module tb_dmem_bus_arbiter;
  import dmem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req   = '0;
  logic [2:0]  wr    = '0;
  logic [2:0]  rd    = '0;
  logic [23:0] addr  = '0;
  logic [23:0] wdata = '0;
  logic [7:0]  mrd   = '0;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(8), .DATA_W(8)) bus ();
  dmem_bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(8), .DATA_W(8)) bus_wd ();

  assign bus.m_req       = req;
  assign bus.m_wr        = wr;
  assign bus.m_rd        = rd;
  assign bus.m_addr      = addr;
  assign bus.m_wdata     = wdata;
  assign bus.mem_rdata   = mrd;
  assign bus_wd.m_req    = req;
  assign bus_wd.m_wr     = wr;
  assign bus_wd.m_rd     = rd;
  assign bus_wd.m_addr   = addr;
  assign bus_wd.m_wdata  = wdata;
  assign bus_wd.mem_rdata = mrd;

  dmem_bus_arbiter #(
    .NUM_MASTERS (3),
    .ADDR_W      (8),
    .DATA_W      (8),
    .MAX_HOLD    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_bus_arbiter #(
    .NUM_MASTERS (3),
    .ADDR_W      (8),
    .DATA_W      (8),
    .MAX_HOLD    (4)
  ) dut_wd (
    .clk (clk),
    .rst (rst),
    .bus (bus_wd)
  );

  localparam logic [2:0] G_CPU   = 3'(1 << MASTER_CPU);
  localparam logic [2:0] G_STACK = 3'(1 << MASTER_STACK);
  localparam logic [2:0] G_DMA   = 3'(1 << MASTER_DMA);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  logic [2:0] rr_exp [4];

  initial begin
    rr_exp[0] = G_CPU;
    rr_exp[1] = G_STACK;
    rr_exp[2] = G_DMA;
    rr_exp[3] = G_CPU;

    // Reset state
    mrd = 8'h5A;
    tick;
    tick;
    chk("rst_grant", 32'(bus.m_grant), 32'h0);
    chk("rst_wr", 32'(bus.mem_wr), 32'h0);
    chk("rst_rd", 32'(bus.mem_rd), 32'h0);
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    chk("rst_tid", 32'(bus.timeout_id), 32'h0);
    chk("rst_perr", 32'(bus.proto_err), 32'h0);
    chk("rdata_pass", 32'(bus.m_rdata), 32'h5A);

    // First grant after reset goes to master 0; then async reset mid-OWN
    rst   = 1'b1;
    req   = 3'b111;
    addr  = 24'h302010;
    wdata = 24'hC3B2A1;
    wr    = 3'b001;
    settle;
    chk("arb_nogrant", 32'(bus.m_grant), 32'h0);
    tick;
    chk("first_grant", 32'(bus.m_grant), 32'(G_CPU));
    chk("first_addr", 32'(bus.mem_addr), 32'h10);
    chk("first_wr", 32'(bus.mem_wr), 32'h1);
    chk("first_wdata", 32'(bus.mem_wdata), 32'hA1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_grant", 32'(bus.m_grant), 32'h0);
    chk("async_wr", 32'(bus.mem_wr), 32'h0);
    chk("async_rd", 32'(bus.mem_rd), 32'h0);
    chk("async_addr", 32'(bus.mem_addr), 32'h0);
    req = '0;
    wr  = '0;
    tick;
    rst = 1'b1;

    // Round-robin with all masters requesting, each owning one cycle
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("rr_grant%0d", k), 32'(bus.m_grant), 32'(rr_exp[k]));
      req = (k == 3) ? 3'b000 : ~rr_exp[k];
      tick;
      chk($sformatf("rr_rel%0d", k), 32'(bus.m_grant), 32'h0);
      req = (k == 3) ? 3'b000 : 3'b111;
      tick;
      chk($sformatf("rr_arb%0d", k), 32'(bus.m_grant), 32'h0);
    end

    // Stack unit 3-byte push
    req  = G_STACK;
    wr   = G_STACK;
    addr = 24'h00FD00;
    tick;
    chk("stk_grant", 32'(bus.m_grant), 32'(G_STACK));
    chk("stk_addr0", 32'(bus.mem_addr), 32'hFD);
    chk("stk_wr0", 32'(bus.mem_wr), 32'h1);
    tick;
    addr = 24'h00FE00;
    settle;
    chk("stk_addr1", 32'(bus.mem_addr), 32'hFE);
    tick;
    addr = 24'h00FF00;
    settle;
    chk("stk_addr2", 32'(bus.mem_addr), 32'hFF);
    chk("stk_wr2", 32'(bus.mem_wr), 32'h1);
    tick;
    req = '0;
    wr  = '0;
    settle;
    chk("stk_drop_grant", 32'(bus.m_grant), 32'(G_STACK));
    chk("stk_drop_wr", 32'(bus.mem_wr), 32'h0);
    tick;
    chk("stk_rel_grant", 32'(bus.m_grant), 32'h0);
    chk("stk_rel_addr", 32'(bus.mem_addr), 32'hFF);
    tick;

    // No preemption: master 0 owns 5 cycles while master 1 waits
    req  = G_CPU;
    rd   = G_CPU;
    addr = 24'h000042;
    tick;
    chk("np_grant1", 32'(bus.m_grant), 32'(G_CPU));
    chk("np_rd", 32'(bus.mem_rd), 32'h1);
    chk("np_addr", 32'(bus.mem_addr), 32'h42);
    tick;
    req = G_CPU | G_STACK;
    settle;
    chk("np_grant2", 32'(bus.m_grant), 32'(G_CPU));
    tick;
    chk("np_grant3", 32'(bus.m_grant), 32'(G_CPU));
    tick;
    chk("np_grant4", 32'(bus.m_grant), 32'(G_CPU));
    tick;
    req = G_STACK;
    rd  = '0;
    settle;
    chk("np_grant5", 32'(bus.m_grant), 32'(G_CPU));
    tick;
    chk("np_rel", 32'(bus.m_grant), 32'h0);
    tick;
    chk("np_arb", 32'(bus.m_grant), 32'h0);
    tick;
    chk("np_next", 32'(bus.m_grant), 32'(G_STACK));

    // Protocol error: owner 1 strobes write and read together
    wr    = G_STACK;
    rd    = G_STACK;
    wdata = 24'h00A500;
    settle;
    chk("pe_wr", 32'(bus.mem_wr), 32'h1);
    chk("pe_rd", 32'(bus.mem_rd), 32'h0);
    chk("pe_wdata", 32'(bus.mem_wdata), 32'hA5);
    chk("pe_pulse", 32'(bus.proto_err), 32'h1);
    tick;
    rd = '0;
    settle;
    chk("pe_clear", 32'(bus.proto_err), 32'h0);
    chk("pe_wr_only", 32'(bus.mem_wr), 32'h1);
    tick;
    req = '0;
    wr  = '0;
    tick;
    chk("pe_rel_grant", 32'(bus.m_grant), 32'h0);
    chk("pe_rel_wdata", 32'(bus.mem_wdata), 32'hA5);
    tick;

    // Watchdog on the MAX_HOLD=4 instance
    rst = 1'b0;
    settle;
    chk("wd_rst_grant", 32'(bus_wd.m_grant), 32'h0);
    tick;
    rst = 1'b1;
    req = G_DMA;
    tick;
    chk("wd_grant1", 32'(bus_wd.m_grant), 32'(G_DMA));
    req = G_DMA | G_CPU;
    tick;
    chk("wd_grant2", 32'(bus_wd.m_grant), 32'(G_DMA));
    chk("wd_to2", 32'(bus_wd.timeout), 32'h0);
    tick;
    chk("wd_grant3", 32'(bus_wd.m_grant), 32'(G_DMA));
    tick;
    chk("wd_grant4", 32'(bus_wd.m_grant), 32'(G_DMA));
    chk("wd_to4", 32'(bus_wd.timeout), 32'h0);
    tick;
    chk("wd_rev_grant", 32'(bus_wd.m_grant), 32'h0);
    chk("wd_timeout", 32'(bus_wd.timeout), 32'h1);
    chk("wd_tid", 32'(bus_wd.timeout_id), 32'h2);
    chk("wd16_grant", 32'(bus.m_grant), 32'(G_DMA));
    chk("wd16_timeout", 32'(bus.timeout), 32'h0);
    tick;
    chk("wd_to_end", 32'(bus_wd.timeout), 32'h0);
    chk("wd_tid_hold", 32'(bus_wd.timeout_id), 32'h2);
    chk("wd_arb_grant", 32'(bus_wd.m_grant), 32'h0);
    tick;
    chk("wd_next", 32'(bus_wd.m_grant), 32'(G_CPU));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
